// File: rtl/drum_voice_player.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | drum_voice_player                                                          |
// | One-voice drum sample player: ROM fetch per sample tick, velocity scaling. |
// | Optional macro DRUM_VOICE_OVERRUN_EN adds a sticky dropped-tick flag.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module drum_voice_player #(
    parameter int ADDR_W   = 16,
    parameter int SAMPLE_W = 16,
    parameter int VEL_W    = 7
) (
    input  logic                CLOCK_50,
    input  logic                RESET_N,
    input  logic                sample_clk,
    input  logic                trigger,
    input  logic [VEL_W-1:0]    velocity,
    input  logic [ADDR_W-1:0]   sample_len,
    output logic                rom_rd,
    output logic [ADDR_W-1:0]   rom_addr,
    input  logic [SAMPLE_W-1:0] rom_data,
    output logic [SAMPLE_W-1:0] audio_out,
    output logic                audio_valid,
`ifdef DRUM_VOICE_OVERRUN_EN
    output logic                overrun,
`endif
    output logic                busy
);

    localparam int PROD_W = SAMPLE_W + VEL_W + 1;

    localparam logic [1:0] S_WAIT = 2'd0;
    localparam logic [1:0] S_READ = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;
    localparam logic [1:0] S_OUT  = 2'd3;

    logic [1:0]        r_state;
    logic              r_sync1;
    logic              r_sync2;
    logic              r_sync_d;
    logic              r_tick;
    logic [ADDR_W-1:0] r_ptr;
    logic [VEL_W-1:0]  r_vel;
    logic              r_pend;
    logic [VEL_W-1:0]  r_pend_vel;

    logic                     w_trig_ok;
    logic                     w_last;
    logic signed [PROD_W-1:0] w_prod;
    logic [SAMPLE_W-1:0]      w_scaled;

    assign w_trig_ok = trigger && (velocity != '0) && (sample_len != '0);
    assign w_last    = (r_ptr == sample_len - ADDR_W'(1));

    // Velocity is zero-extended so it is always non-negative in the signed product.
    assign w_prod   = $signed({{(VEL_W + 1){rom_data[SAMPLE_W-1]}}, rom_data}) *
                      $signed({{SAMPLE_W{1'b0}}, 1'b0, r_vel});
    assign w_scaled = SAMPLE_W'(w_prod >>> VEL_W);

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_sync_d <= 1'b0;
            r_tick   <= 1'b0;
        end else begin
            r_sync1  <= sample_clk;
            r_sync2  <= r_sync1;
            r_sync_d <= r_sync2;
            r_tick   <= r_sync2 & ~r_sync_d;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state     <= S_WAIT;
            r_ptr       <= '0;
            r_vel       <= '0;
            r_pend      <= 1'b0;
            r_pend_vel  <= '0;
            rom_rd      <= 1'b0;
            rom_addr    <= '0;
            audio_out   <= '0;
            audio_valid <= 1'b0;
            busy        <= 1'b0;
        end else begin
            rom_rd      <= 1'b0;
            audio_valid <= 1'b0;

            if (w_trig_ok) begin
                r_pend     <= 1'b1;
                r_pend_vel <= velocity;
            end

            case (r_state)
                S_WAIT: begin
                    if (r_tick) begin
                        r_state <= S_READ;
                        // A same-cycle trigger wins over an older pending one.
                        if (r_pend || w_trig_ok) begin
                            r_ptr    <= '0;
                            r_vel    <= w_trig_ok ? velocity : r_pend_vel;
                            busy     <= 1'b1;
                            r_pend   <= 1'b0;
                            rom_rd   <= 1'b1;
                            rom_addr <= '0;
                        end else begin
                            rom_rd   <= busy;
                            rom_addr <= r_ptr;
                        end
                    end
                end
                S_READ: begin
                    r_state <= S_DATA;
                end
                S_DATA: begin
                    audio_out   <= busy ? w_scaled : '0;
                    audio_valid <= 1'b1;
                    r_state     <= S_OUT;
                end
                S_OUT: begin
                    if (busy) begin
                        if (w_last) begin
                            busy  <= 1'b0;
                            r_ptr <= '0;
                        end else begin
                            r_ptr <= r_ptr + ADDR_W'(1);
                        end
                    end
                    r_state <= S_WAIT;
                end
                default: begin
                    r_state <= S_WAIT;
                end
            endcase
        end
    end

`ifdef DRUM_VOICE_OVERRUN_EN
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            overrun <= 1'b0;
        end else if (r_tick && (r_state != S_WAIT)) begin
            overrun <= 1'b1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_drum_voice_player.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_drum_voice_player                                                       |
// | Directed bench for drum_voice_player with a one-cycle-latency ROM model.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_drum_voice_player;

    logic        CLOCK_50;
    logic        RESET_N;
    logic        sample_clk;
    logic        trigger;
    logic [6:0]  velocity;
    logic [15:0] sample_len;
    logic        rom_rd;
    logic [15:0] rom_addr;
    logic [15:0] rom_data;
    logic [15:0] audio_out;
    logic        audio_valid;
    logic        busy;
`ifdef DRUM_VOICE_OVERRUN_EN
    logic        overrun;
`endif

    logic signed [15:0] mem [0:15];

    int errors = 0;
    int checks = 0;

    logic               v_rd;
    logic [15:0]        v_addr;
    logic signed [15:0] v_out;
    int                 v_nvalid;
    int                 v_rd_cyc;
    int                 v_val_cyc;
    logic               v_busy;

    drum_voice_player #(.ADDR_W(16), .SAMPLE_W(16), .VEL_W(7)) dut (
        .CLOCK_50    (CLOCK_50),
        .RESET_N     (RESET_N),
        .sample_clk  (sample_clk),
        .trigger     (trigger),
        .velocity    (velocity),
        .sample_len  (sample_len),
        .rom_rd      (rom_rd),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .audio_out   (audio_out),
        .audio_valid (audio_valid),
`ifdef DRUM_VOICE_OVERRUN_EN
        .overrun     (overrun),
`endif
        .busy        (busy)
    );

    initial begin
        CLOCK_50 = 1'b0;
        forever #10 CLOCK_50 = ~CLOCK_50;
    end

    // Unread cycles return a marker so a read without strobe shows up.
    always @(posedge CLOCK_50) begin
        rom_data <= rom_rd ? mem[rom_addr[3:0]] : 16'h5A5A;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic pulse_trigger(input logic [6:0] vel);
        trigger  = 1'b1;
        velocity = vel;
        step();
        trigger  = 1'b0;
    endtask

    // One sample period; optionally injects a trigger before edge number trig_at+1.
    task automatic do_tick(input int trig_at, input logic [6:0] trig_vel);
        v_rd = 1'b0; v_addr = '0; v_out = '0;
        v_nvalid = 0; v_rd_cyc = -1; v_val_cyc = -1;
        sample_clk = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (i == trig_at) begin
                trigger  = 1'b1;
                velocity = trig_vel;
            end
            step();
            trigger = 1'b0;
            if (rom_rd && !v_rd) begin
                v_rd = 1'b1; v_addr = rom_addr; v_rd_cyc = i + 1;
            end
            if (audio_valid) begin
                if (v_nvalid == 0) begin
                    v_out = audio_out; v_val_cyc = i + 1;
                end
                v_nvalid++;
            end
        end
        sample_clk = 1'b0;
        repeat (6) step();
        v_busy = busy;
    endtask

    task automatic tick_expect(input string tag, input logic rd, input int addr,
                               input int out, input logic busy_after);
        chk({tag, "_nvalid"}, v_nvalid, 1);
        chk({tag, "_rd"}, int'(v_rd), int'(rd));
        if (rd) chk({tag, "_addr"}, int'(v_addr), addr);
        chk({tag, "_out"}, int'(v_out), out);
        chk({tag, "_busy"}, int'(v_busy), int'(busy_after));
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = '0;
        mem[0] = 16'sd1000;
        mem[1] = -16'sd1000;
        mem[2] = 16'sd32767;
        mem[3] = -16'sd32768;
        RESET_N = 1'b0; sample_clk = 1'b0; trigger = 1'b0;
        velocity = '0; sample_len = 16'd4;
        repeat (3) step();
        chk("rst_rom_rd", int'(rom_rd), 0);
        chk("rst_rom_addr", int'(rom_addr), 0);
        chk("rst_audio_out", int'(audio_out), 0);
        chk("rst_audio_valid", int'(audio_valid), 0);
        chk("rst_busy", int'(busy), 0);
`ifdef DRUM_VOICE_OVERRUN_EN
        chk("rst_overrun", int'(overrun), 0);
`endif
        RESET_N = 1'b1;
        repeat (3) step();

        // Idle ticks keep the DAC fed with zeros.
        for (int k = 0; k < 3; k++) begin
            do_tick(-1, '0);
            tick_expect($sformatf("idle%0d", k), 1'b0, 0, 0, 1'b0);
        end

        // Basic play at full velocity, including pipeline latency.
        pulse_trigger(7'd127);
        do_tick(-1, '0);
        tick_expect("play0", 1'b1, 0, 992, 1'b1);
        chk("lat_rd_edge", v_rd_cyc, 4);
        chk("lat_valid_edge", v_val_cyc, 6);
        do_tick(-1, '0);
        tick_expect("play1", 1'b1, 1, -993, 1'b1);
        do_tick(-1, '0);
        tick_expect("play2", 1'b1, 2, 32511, 1'b1);
        do_tick(-1, '0);
        tick_expect("play3", 1'b1, 3, -32512, 1'b0);
        do_tick(-1, '0);
        tick_expect("play_end", 1'b0, 0, 0, 1'b0);

        // Half velocity rounds toward minus infinity.
        mem[0] = -16'sd3;
        sample_len = 16'd1;
        pulse_trigger(7'd64);
        do_tick(-1, '0);
        tick_expect("half", 1'b1, 0, -2, 1'b0);
        mem[0] = 16'sd1000;
        sample_len = 16'd4;

        // Retrigger while the ptr=2 word is in flight.
        pulse_trigger(7'd127);
        do_tick(-1, '0);
        do_tick(-1, '0);
        tick_expect("rt_ptr1", 1'b1, 1, -993, 1'b1);
        do_tick(4, 7'd32);
        tick_expect("rt_inflight", 1'b1, 2, 32511, 1'b1);
        do_tick(-1, '0);
        tick_expect("rt_restart", 1'b1, 0, 250, 1'b1);
        do_tick(4, 7'd0);
        tick_expect("rt_vel0_ignored", 1'b1, 1, -250, 1'b1);
        do_tick(-1, '0);
        tick_expect("rt_cont", 1'b1, 2, 8191, 1'b1);

        // Last trigger before a tick wins.
        pulse_trigger(7'd127);
        step();
        pulse_trigger(7'd64);
        do_tick(-1, '0);
        tick_expect("last_wins", 1'b1, 0, 500, 1'b1);

        // Reset during the ptr=1 read aborts at once.
        sample_clk = 1'b1;
        repeat (4) step();
        chk("pre_reset_rd", int'(rom_rd), 1);
        chk("pre_reset_addr", int'(rom_addr), 1);
        RESET_N = 1'b0;
        #1;
        chk("mid_rst_rom_rd", int'(rom_rd), 0);
        chk("mid_rst_rom_addr", int'(rom_addr), 0);
        chk("mid_rst_audio_out", int'(audio_out), 0);
        chk("mid_rst_busy", int'(busy), 0);
        repeat (2) step();
        sample_clk = 1'b0;
        RESET_N = 1'b1;
        repeat (4) step();
        do_tick(-1, '0);
        tick_expect("post_rst_idle", 1'b0, 0, 0, 1'b0);

        // Zero length sample makes triggers ineffective.
        sample_len = 16'd0;
        pulse_trigger(7'd100);
        do_tick(-1, '0);
        tick_expect("len0_ignored", 1'b0, 0, 0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
